// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        HOLD,
        DRAIN
    } fetchState_t;

    localparam logic [31:0] NOP_INSN         = 32'h0000_0000;
    localparam logic [31:0] PC_STEP          = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Instruction addresses are word aligned; low two bits are dropped.
    function automatic logic [31:0] alignPc(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_fetch_unit_hold_buf.sv
// One-entry instruction/PC holding register used while the IF/ID stage is stalled.
module fetch_hold_buf
    import if_pkg::*;
(
    input  logic        clk_i,
    input  logic        clear,
    input  logic        load,
    input  logic [31:0] newInsn,
    input  logic [31:0] newPc,
    output logic [31:0] heldInsn,
    output logic [31:0] heldPc
);

    always_ff @(posedge clk_i) begin
        if (clear) begin
            heldInsn <= NOP_INSN;
            heldPc   <= '0;
        end else if (load) begin
            heldInsn <= newInsn;
            heldPc   <= newPc;
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs the imem req/ready handshake and
// feeds the IF/ID register, honouring its stall (priority) and flush signals.
module if_fetch_unit
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic [31:0] branch_target_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ready_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] insn_o,
    output logic [31:0] pc_o,
    output logic        valid_o
);

    fetchState_t state, nextState;
    logic [31:0] pc, pcNext;
    logic [31:0] redirPc, redirNext;
    logic [31:0] target;
    logic        takeFlush;
    logic        bufLoad;
    logic [31:0] bufInsn, bufPc;
    logic        outValid;
    logic [31:0] outInsn, outPc;

    assign target    = alignPc(branch_target_i);
    assign takeFlush = flush_i & ~stall_i;

    fetch_hold_buf holdBuf (
        .clk_i    (clk_i),
        .clear    (rst_i),
        .load     (bufLoad),
        .newInsn  (imem_rdata_i),
        .newPc    (pc),
        .heldInsn (bufInsn),
        .heldPc   (bufPc)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= IDLE;
            pc      <= RESET_PC;
            redirPc <= '0;
        end else begin
            state   <= nextState;
            pc      <= pcNext;
            redirPc <= redirNext;
        end
    end

    always_comb begin
        nextState  = state;
        pcNext     = pc;
        redirNext  = redirPc;
        bufLoad    = 1'b0;
        imem_req_o = 1'b0;
        outValid   = 1'b0;
        outInsn    = imem_rdata_i;
        outPc      = pc;
        case (state)
            IDLE: begin
                if (start_i) nextState = FETCH;
            end
            FETCH: begin
                imem_req_o = 1'b1;
                if (imem_ready_i) begin
                    if (stall_i) begin
                        // Presented now, but IF/ID will not take it: keep a copy.
                        outValid  = 1'b1;
                        bufLoad   = 1'b1;
                        pcNext    = pc + PC_STEP;
                        nextState = HOLD;
                    end else if (flush_i) begin
                        pcNext = target;
                    end else begin
                        outValid = 1'b1;
                        pcNext   = pc + PC_STEP;
                    end
                end else if (takeFlush) begin
                    redirNext = target;
                    nextState = DRAIN;
                end
            end
            HOLD: begin
                outInsn = bufInsn;
                outPc   = bufPc;
                if (stall_i) begin
                    outValid = 1'b1;
                end else if (flush_i) begin
                    pcNext    = target;
                    nextState = FETCH;
                end else begin
                    outValid  = 1'b1;
                    nextState = FETCH;
                end
            end
            DRAIN: begin
                // Old request must retire before the redirect takes effect.
                imem_req_o = 1'b1;
                if (imem_ready_i) begin
                    pcNext    = takeFlush ? target : redirPc;
                    nextState = FETCH;
                end else if (takeFlush) begin
                    redirNext = target;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    assign imem_addr_o = pc;
    assign valid_o     = outValid;
    assign insn_o      = outValid ? outInsn : NOP_INSN;
    assign pc_o        = outValid ? outPc : '0;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: directed scenarios plus random
// stall/flush/ready traffic compared against a behavioural model.
module tb_if_fetch_unit;

    localparam logic [31:0] DATA_KEY = 32'hA5A5_0000;
    localparam logic [31:0] WRAP_PC  = 32'hFFFF_FFF8;

    logic        clk = 1'b0;
    logic        rst, start, stall, flush, ready;
    logic [31:0] target;

    logic        req0, valid0, req1, valid1;
    logic [31:0] addr0, insn0, pcOut0, addr1, insn1, pcOut1;
    logic [31:0] rdata0, rdata1;

    assign rdata0 = addr0 ^ DATA_KEY;
    assign rdata1 = addr1 ^ DATA_KEY;

    always #5 clk = ~clk;

    if_fetch_unit dut0 (
        .clk_i(clk), .rst_i(rst), .start_i(start), .stall_i(stall), .flush_i(flush),
        .branch_target_i(target), .imem_req_o(req0), .imem_addr_o(addr0),
        .imem_ready_i(ready), .imem_rdata_i(rdata0), .insn_o(insn0), .pc_o(pcOut0),
        .valid_o(valid0)
    );

    if_fetch_unit #(.RESET_PC(WRAP_PC)) dut1 (
        .clk_i(clk), .rst_i(rst), .start_i(start), .stall_i(stall), .flush_i(flush),
        .branch_target_i(target), .imem_req_o(req1), .imem_addr_o(addr1),
        .imem_ready_i(ready), .imem_rdata_i(rdata1), .insn_o(insn1), .pc_o(pcOut1),
        .valid_o(valid1)
    );

    int checks = 0;
    int errors = 0;
    int sel    = 0;

    // Reference model: running/holding/draining flags plus plain PC arithmetic.
    bit          mRun, mHeld, mDrain;
    logic [31:0] mPc, mBufInsn, mBufPc, mRedir, mResetPc;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic modelReset();
        mRun = 0; mHeld = 0; mDrain = 0;
        mPc = mResetPc; mBufInsn = '0; mBufPc = '0; mRedir = '0;
    endtask

    function automatic logic [31:0] curAddr();
        return (sel != 0) ? addr1 : addr0;
    endfunction

    // Check this cycle's outputs at the falling edge, then advance the model at the rising edge.
    task automatic doCycle();
        logic        eReq, eValid, kill;
        logic [31:0] eInsn, ePc, tgt;
        @(negedge clk);
        kill = flush && !stall;
        tgt  = {target[31:2], 2'b00};
        eReq = 0; eValid = 0; eInsn = '0; ePc = '0;
        if (mRun && mHeld) begin
            eValid = stall || !flush;
            eInsn  = mBufInsn; ePc = mBufPc;
        end else if (mRun && mDrain) begin
            eReq = 1;
        end else if (mRun) begin
            eReq   = 1;
            eValid = ready && (stall || !flush);
            eInsn  = mPc ^ DATA_KEY; ePc = mPc;
        end
        if (!eValid) begin eInsn = '0; ePc = '0; end
        checkVal("req",   {31'd0, (sel != 0) ? req1 : req0},     {31'd0, eReq});
        checkVal("addr",  curAddr(),                            mPc);
        checkVal("valid", {31'd0, (sel != 0) ? valid1 : valid0}, {31'd0, eValid});
        checkVal("insn",  (sel != 0) ? insn1 : insn0,           eInsn);
        checkVal("pc",    (sel != 0) ? pcOut1 : pcOut0,         ePc);
        @(posedge clk);
        if (rst) begin
            modelReset();
        end else if (!mRun) begin
            mRun = start;
        end else if (mHeld) begin
            if (!stall) begin
                mHeld = 0;
                if (flush) mPc = tgt;
            end
        end else if (mDrain) begin
            if (ready) begin
                mPc = kill ? tgt : mRedir;
                mDrain = 0;
            end else if (kill) begin
                mRedir = tgt;
            end
        end else if (ready) begin
            if (stall) begin
                mBufInsn = mPc ^ DATA_KEY; mBufPc = mPc;
                mPc = mPc + 32'd4; mHeld = 1;
            end else if (flush) begin
                mPc = tgt;
            end else begin
                mPc = mPc + 32'd4;
            end
        end else if (kill) begin
            mRedir = tgt; mDrain = 1;
        end
        #1;
    endtask

    task automatic quiet();
        rst = 0; start = 0; stall = 0; flush = 0; ready = 1; target = '0;
    endtask

    task automatic resetAndStart();
        quiet();
        rst = 1;
        doCycle();
        doCycle();
        rst = 0; start = 1;
        doCycle();
        start = 0;
    endtask

    initial begin
        quiet();
        rst = 1;
        mResetPc = '0;
        modelReset();
        @(posedge clk); #1;

        // Reset state, then zero-wait streaming.
        resetAndStart();
        for (int i = 0; i < 12; i++) doCycle();

        // Ready every third cycle.
        for (int i = 0; i < 15; i++) begin
            ready = (i % 3 == 2);
            doCycle();
        end

        // Stall on the fetch at 0x10 for three cycles.
        resetAndStart();
        for (int i = 0; i < 20 && curAddr() != 32'h10; i++) doCycle();
        checkVal("reach10", curAddr(), 32'h10);
        stall = 1;
        for (int i = 0; i < 3; i++) doCycle();
        stall = 0;
        for (int i = 0; i < 3; i++) doCycle();

        // Flush at 0x20 to 0x103 with zero-wait memory.
        for (int i = 0; i < 20 && curAddr() != 32'h20; i++) doCycle();
        checkVal("reach20", curAddr(), 32'h20);
        flush = 1; target = 32'h103;
        doCycle();
        flush = 0;
        for (int i = 0; i < 3; i++) doCycle();

        // Flush during a waited request, second flush while draining.
        ready = 0; flush = 1; target = 32'h200;
        doCycle();
        target = 32'h300;
        doCycle();
        flush = 0;
        doCycle();
        ready = 1;
        doCycle();
        checkVal("drainAddr", curAddr(), 32'h300);
        doCycle();
        // Stall together with flush must not redirect.
        stall = 1; flush = 1; target = 32'h400;
        doCycle();
        doCycle();
        stall = 0; flush = 0;
        for (int i = 0; i < 3; i++) doCycle();

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            rst    = ($urandom % 101) == 0;
            start  = ($urandom % 3) == 0;
            stall  = ($urandom % 4) == 0;
            flush  = ($urandom % 6) == 0;
            ready  = ($urandom % 3) != 0;
            target = $urandom;
            doCycle();
        end

        // Wrap-around from 0xFFFF_FFF8, then reset in the middle of a request.
        sel = 1;
        mResetPc = WRAP_PC;
        resetAndStart();
        for (int i = 0; i < 3; i++) doCycle();
        ready = 0;
        doCycle();
        rst = 1;
        doCycle();
        rst = 0;
        for (int i = 0; i < 3; i++) doCycle();
        checkVal("idleAddr", curAddr(), WRAP_PC);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
